// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC thermometer pop-count sequencer and its capture block.
package tdc_pkg;

    localparam int TDC_N = 64;
    localparam int TDC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } tdc_state_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/tdc_pop_seq_pop_count.sv
// Narrow population counter with a one-cycle registered output; updates only when en is high.
module pop_count_simple #(
    parameter int    N      = 16,
    parameter string METHOD = "SV"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         x,
    output logic [$clog2(N):0]   y
);

    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_reg;

    generate
        if (METHOD == "LOOP") begin : g_loop
            always_comb begin
                cnt_next = '0;
                for (int i = 0; i < N; i++) begin
                    cnt_next = cnt_next + CW'(x[i]);
                end
            end
        end else begin : g_sv
            always_comb begin
                cnt_next = CW'($countones(x));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_next;
        end
    end

    assign y = cnt_reg;

endmodule

// File: rtl/tdc_pop_seq.sv
// Time-multiplexes one W-bit pop counter across an N-bit TDC snapshot and returns the total on valid/ready.
// Optional thermometer bubble detection is built when TDC_POP_SEQ_BUBBLE_EN is defined.
module tdc_pop_seq
    import tdc_pkg::*;
#(
    parameter int    N          = TDC_N,
    parameter int    W          = TDC_W,
    parameter string POP_METHOD = "SV"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          x,
    output logic                  busy,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [cnt_w(N)-1:0]   y,
    output logic                  bubble_err
);

    localparam int NCH  = N / W;
    localparam int CW   = cnt_w(N);
    localparam int PW   = cnt_w(W);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    tdc_state_t     state_reg, state_next;
    logic [N-1:0]   snap_reg, snap_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [CW-1:0]  acc_reg, acc_next;
    logic           pend_reg;
    logic [PW-1:0]  part;
    logic           cnt_en;
    logic [W-1:0]   chunk;
    logic [W-1:0]   chunk_arr [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            assign chunk_arr[gi] = snap_reg[gi*W +: W];
        end
    endgenerate

    assign chunk  = chunk_arr[idx_reg];
    assign cnt_en = (state_reg == ST_ISSUE);

    pop_count_simple #(
        .N      (W),
        .METHOD (POP_METHOD)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .x   (chunk),
        .y   (part)
    );

    always_comb begin
        state_next = state_reg;
        snap_next  = snap_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        // The counter result lags the issue by one cycle, so the add trails by one state.
        if (pend_reg) begin
            acc_next = acc_reg + CW'(part);
        end
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    snap_next  = x;
                    idx_next   = '0;
                    acc_next   = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = ST_DRAIN;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (y_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            snap_reg  <= '0;
            idx_reg   <= '0;
            acc_reg   <= '0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            snap_reg  <= snap_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            pend_reg  <= cnt_en;
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign y_valid = (state_reg == ST_HOLD);
    assign y       = acc_reg;

`ifdef TDC_POP_SEQ_BUBBLE_EN
    logic bubble_reg;
    logic prev_msb_reg;
    logic chunk_bubble;

    always_comb begin
        chunk_bubble = 1'b0;
        for (int j = 0; j < W - 1; j++) begin
            if (!chunk[j] && chunk[j+1]) begin
                chunk_bubble = 1'b1;
            end
        end
        // Pair straddling the boundary with the previously issued chunk.
        if ((idx_reg != '0) && !prev_msb_reg && chunk[0]) begin
            chunk_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_reg   <= 1'b0;
            prev_msb_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                bubble_reg <= 1'b0;
            end else if (state_reg == ST_ISSUE && chunk_bubble) begin
                bubble_reg <= 1'b1;
            end
            if (state_reg == ST_ISSUE) begin
                prev_msb_reg <= chunk[W-1];
            end
        end
    end

    assign bubble_err = bubble_reg;
`else
    assign bubble_err = 1'b0;
`endif

endmodule
